// File: rtl/mdu_issue_if.sv
// ID-stage <-> MDU issue controller bundle: decoded-stage inputs plus issue,
// interlock and HI/LO write outputs.
interface mdu_issue_if #(
  parameter int CNT_W = 6
);
  logic             id_valid;
  logic [31:0]      instr;
  logic             flush;
  logic             stall_out;
  logic             mul_start_out;
  logic             div_start_out;
  logic             mdu_sign_out;
  logic             mdu_div_out;
  logic             busy_out;
  logic             hilo_wena_out;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output id_valid, instr, flush,
    input  stall_out, mul_start_out, div_start_out, mdu_sign_out,
           mdu_div_out, busy_out, hilo_wena_out, cnt_out
  );

  modport slave (
    input  id_valid, instr, flush,
    output stall_out, mul_start_out, div_start_out, mdu_sign_out,
           mdu_div_out, busy_out, hilo_wena_out, cnt_out
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issue/interlock controller for a multi-cycle multiply/divide unit: decodes the
// ID instruction, starts the unit, counts latency, stalls on HI/LO hazards.
module mdu_issue_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input logic        clk,
  input logic        rst,
  mdu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             sign_r, sign_nxt_s;
  logic             div_r, div_nxt_s;
  logic             held_r, held_nxt_s;

  logic [5:0] op_s, func_s;
  logic       valid_s, special_s, special2_s;
  logic       is_mul_s, is_multu_s, is_div_s, is_divu_s, is_mdu_s, is_hilo_s;
  logic       stall_s, mul_start_s, div_start_s, sign_s, divf_s, busy_s, hilo_s;

  assign op_s       = bus.instr[31:26];
  assign func_s     = bus.instr[5:0];
  assign valid_s    = bus.id_valid & ~bus.flush;
  assign special_s  = (op_s == 6'h00);
  assign special2_s = (op_s == 6'h1C);

  // Strict field decode: unused register/shamt fields must be zero
  assign is_mul_s   = valid_s & special2_s & (func_s == 6'h02) & (bus.instr[10:6] == 5'd0);
  assign is_multu_s = valid_s & special_s & (func_s == 6'h19) & (bus.instr[15:6] == 10'd0);
  assign is_div_s   = valid_s & special_s & (func_s == 6'h1A) & (bus.instr[15:6] == 10'd0);
  assign is_divu_s  = valid_s & special_s & (func_s == 6'h1B) & (bus.instr[15:6] == 10'd0);
  assign is_mdu_s   = is_mul_s | is_multu_s | is_div_s | is_divu_s;
  assign is_hilo_s  = valid_s & special_s & (
                        (((func_s == 6'h10) | (func_s == 6'h12)) &
                         (bus.instr[25:16] == 10'd0) & (bus.instr[10:6] == 5'd0)) |
                        (((func_s == 6'h11) | (func_s == 6'h13)) &
                         (bus.instr[20:6] == 15'd0)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counter and in-flight operation flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      sign_r <= 1'b0;
      div_r  <= 1'b0;
      held_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      sign_r <= sign_nxt_s;
      div_r  <= div_nxt_s;
      held_r <= held_nxt_s;
    end
  end

  // Next-state: held_r marks a MUL still sitting in ID, so a flush aborts it
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sign_nxt_s  = sign_r;
    div_nxt_s   = div_r;
    held_nxt_s  = held_r;
    case (state_r)
      IDLE: begin
        if (is_mul_s | is_multu_s) begin
          state_nxt_s = MUL_BUSY;
          cnt_nxt_s   = MUL_LAST;
          sign_nxt_s  = is_mul_s;
          div_nxt_s   = 1'b0;
          held_nxt_s  = is_mul_s;
        end else if (is_div_s | is_divu_s) begin
          state_nxt_s = DIV_BUSY;
          cnt_nxt_s   = DIV_LAST;
          sign_nxt_s  = is_div_s;
          div_nxt_s   = 1'b1;
          held_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if ((held_r & bus.flush) | (cnt_r == '0)) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          sign_nxt_s  = 1'b0;
          div_nxt_s   = 1'b0;
          held_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        sign_nxt_s  = 1'b0;
        div_nxt_s   = 1'b0;
        held_nxt_s  = 1'b0;
      end
    endcase
  end

  // Outputs: starts are combinational in the issue cycle
  always_comb begin
    stall_s     = 1'b0;
    mul_start_s = 1'b0;
    div_start_s = 1'b0;
    sign_s      = 1'b0;
    divf_s      = 1'b0;
    busy_s      = 1'b0;
    hilo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        mul_start_s = is_mul_s | is_multu_s;
        div_start_s = is_div_s | is_divu_s;
        stall_s     = is_mul_s;
      end
      MUL_BUSY, DIV_BUSY: begin
        busy_s = 1'b1;
        sign_s = sign_r;
        divf_s = div_r;
        if (held_r) begin
          stall_s = ~bus.flush & (cnt_r != '0);
          hilo_s  = ~bus.flush & (cnt_r == '0);
        end else begin
          stall_s = is_mdu_s | is_hilo_s;
          hilo_s  = (cnt_r == '0);
        end
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Reset forces every output low even while rst is held
  assign bus.stall_out     = stall_s & ~rst;
  assign bus.mul_start_out = mul_start_s & ~rst;
  assign bus.div_start_out = div_start_s & ~rst;
  assign bus.mdu_sign_out  = sign_s & ~rst;
  assign bus.mdu_div_out   = divf_s & ~rst;
  assign bus.busy_out      = busy_s & ~rst;
  assign bus.hilo_wena_out = hilo_s & ~rst;
  assign bus.cnt_out       = cnt_r & {CNT_W{~rst}};

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl (MUL_CYCLES=4, DIV_CYCLES=33): every output
// is checked each cycle against hand-computed vectors.
module tb_mdu_issue_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MUL   = 32'h7022_1802;
  localparam logic [31:0] MULTU = 32'h0022_0019;
  localparam logic [31:0] DIV   = 32'h0022_001A;
  localparam logic [31:0] DIVU  = 32'h0022_001B;
  localparam logic [31:0] MFHI  = 32'h0000_1810;
  localparam logic [31:0] MFLO  = 32'h0000_1812;
  localparam logic [31:0] MTHI  = 32'h0020_0011;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mdu_issue_if #(.CNT_W(6)) bus ();

  mdu_issue_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, mul_start, div_start, sign, div, busy, hilo_wena, cnt[5:0]}
  logic [12:0] obs;
  assign obs = {bus.stall_out, bus.mul_start_out, bus.div_start_out, bus.mdu_sign_out,
                bus.mdu_div_out, bus.busy_out, bus.hilo_wena_out, bus.cnt_out};

  function automatic logic [12:0] e(input logic st, input logic ms, input logic ds,
                                    input logic sg, input logic dv, input logic bz,
                                    input logic hw, input int c);
    logic [5:0] cc;
    cc = c[5:0];
    return {st, ms, ds, sg, dv, bz, hw, cc};
  endfunction

  task automatic drv(input logic v, input logic [31:0] ins, input logic fl);
    bus.id_valid = v;
    bus.instr    = ins;
    bus.flush    = fl;
  endtask

  // Check mid-cycle, then advance to just after the next rising edge
  task automatic chk(input string tag, input logic [12:0] exp);
    @(negedge clk);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drv(1'b1, MULTU, 1'b0);
    chk("rst_gate", e(0,0,0,0,0,0,0,0));
    chk("rst_hold", e(0,0,0,0,0,0,0,0));
    rst = 1'b0;
    drv(1'b0, NOP, 1'b0);
    chk("idle", e(0,0,0,0,0,0,0,0));

    // MULTU: no stall, cnt 3..0, write strobe on the cnt==0 cycle
    drv(1'b1, MULTU, 1'b0);
    chk("multu_issue", e(0,1,0,0,0,0,0,0));
    drv(1'b0, NOP, 1'b0);
    for (int k = 3; k >= 0; k--) chk("multu_busy", e(0,0,0,0,0,1,k==0,k));
    chk("multu_done", e(0,0,0,0,0,0,0,0));

    // MUL held in ID until its result cycle
    drv(1'b1, MUL, 1'b0);
    chk("mul_issue", e(1,1,0,0,0,0,0,0));
    for (int k = 3; k >= 0; k--) chk("mul_hold", e(k!=0,0,0,1,0,1,k==0,k));
    drv(1'b0, NOP, 1'b0);
    chk("mul_done", e(0,0,0,0,0,0,0,0));

    // DIV then MFLO waiting on the result
    drv(1'b1, DIV, 1'b0);
    chk("div_issue", e(0,0,1,0,0,0,0,0));
    drv(1'b1, MFLO, 1'b0);
    for (int k = 32; k >= 0; k--) chk("mflo_stall", e(1,0,0,1,1,1,k==0,k));
    chk("mflo_release", e(0,0,0,0,0,0,0,0));

    // Back-to-back DIVU: second issues in the first idle cycle
    drv(1'b1, DIVU, 1'b0);
    chk("divu1_issue", e(0,0,1,0,0,0,0,0));
    for (int k = 32; k >= 0; k--) chk("divu2_stall", e(1,0,0,0,1,1,k==0,k));
    chk("divu2_issue", e(0,0,1,0,0,0,0,0));
    drv(1'b0, NOP, 1'b0);
    for (int k = 32; k >= 0; k--) chk("divu2_busy", e(0,0,0,0,1,1,k==0,k));
    chk("divu2_done", e(0,0,0,0,0,0,0,0));

    // Flush of a held MUL aborts it with no write strobe
    drv(1'b1, MUL, 1'b0);
    chk("mulf_issue", e(1,1,0,0,0,0,0,0));
    chk("mulf_hold", e(1,0,0,1,0,1,0,3));
    drv(1'b1, MUL, 1'b1);
    chk("mulf_flush", e(0,0,0,1,0,1,0,2));
    drv(1'b0, NOP, 1'b0);
    for (int k = 0; k < 5; k++) chk("mulf_abort", e(0,0,0,0,0,0,0,0));

    // Flush of a younger instruction does not disturb an issued DIVU
    drv(1'b1, DIVU, 1'b0);
    chk("divuf_issue", e(0,0,1,0,0,0,0,0));
    drv(1'b0, NOP, 1'b0);
    chk("divuf_busy0", e(0,0,0,0,1,1,0,32));
    drv(1'b1, MFHI, 1'b1);
    chk("divuf_flush", e(0,0,0,0,1,1,0,31));
    drv(1'b0, NOP, 1'b0);
    for (int k = 30; k >= 0; k--) chk("divuf_busy", e(0,0,0,0,1,1,k==0,k));
    chk("divuf_done", e(0,0,0,0,0,0,0,0));

    // Idle corner cases: flushed candidate, HI/LO access, invalid slot
    drv(1'b1, MULTU, 1'b1);
    chk("idle_flush", e(0,0,0,0,0,0,0,0));
    chk("idle_flush_stay", e(0,0,0,0,0,0,0,0));
    drv(1'b1, MTHI, 1'b0);
    chk("idle_hilo", e(0,0,0,0,0,0,0,0));
    drv(1'b0, MULTU, 1'b0);
    chk("idle_invalid", e(0,0,0,0,0,0,0,0));

    // Reset mid-divide, then a clean MULTU
    drv(1'b1, DIV, 1'b0);
    chk("divr_issue", e(0,0,1,0,0,0,0,0));
    drv(1'b0, NOP, 1'b0);
    for (int k = 32; k >= 24; k--) chk("divr_busy", e(0,0,0,1,1,1,0,k));
    rst = 1'b1;
    chk("divr_rst", e(0,0,0,0,0,0,0,0));
    rst = 1'b0;
    chk("divr_after", e(0,0,0,0,0,0,0,0));
    drv(1'b1, MULTU, 1'b0);
    chk("multu2_issue", e(0,1,0,0,0,0,0,0));
    drv(1'b0, NOP, 1'b0);
    for (int k = 3; k >= 0; k--) chk("multu2_busy", e(0,0,0,0,0,1,k==0,k));
    chk("multu2_done", e(0,0,0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
